// File: rtl/line_clear.sv
// Removes every full row from a locked playfield, collapsing the rows above downward,
// and keeps saturating running line and score totals behind a start/busy/done handshake.
module line_clear #(
    parameter int ROWS  = 20,
    parameter int COLS  = 10,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [ROWS-1:0][COLS-1:0]  screen,
    input  logic                       clearScore,
    output logic                       busy,
    output logic                       done,
    output logic [ROWS-1:0][COLS-1:0]  outputScreen,
    output logic [4:0]                 linesCleared,
    output logic [CNT_W-1:0]           totalLines,
    output logic [CNT_W-1:0]           score
);

    localparam int IDX_W = $clog2(ROWS);
    localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(ROWS - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t state;
    state_t next_state;

    logic [ROWS-1:0][COLS-1:0] work;
    logic [ROWS-1:0][COLS-1:0] collapsed;
    logic [IDX_W-1:0]          row;
    logic [4:0]                count;
    logic                      row_full;
    logic                      finishing;
    logic [CNT_W-1:0]          increment;
    logic [CNT_W:0]            score_sum;
    logic [CNT_W:0]            lines_sum;

    assign row_full  = &work[row];
    assign finishing = (state == SCAN) && !row_full && (row == LAST_ROW);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = SCAN;
            SCAN:    if (finishing) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    // Rows at and above the full row each take the row above; the top row refills with zeros.
    always_comb begin
        collapsed = work;
        for (int i = 0; i < ROWS - 1; i++) begin
            if (i >= int'(row)) begin
                collapsed[i] = work[i+1];
            end
        end
        collapsed[ROWS-1] = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            work         <= '0;
            row          <= '0;
            count        <= '0;
            outputScreen <= '0;
            linesCleared <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        work  <= screen;
                        row   <= '0;
                        count <= '0;
                    end
                end
                SCAN: begin
                    if (row_full) begin
                        work  <= collapsed;
                        count <= count + 5'd1;
                    end else if (row != LAST_ROW) begin
                        row <= row + 1'b1;
                    end else begin
                        outputScreen <= work;
                        linesCleared <= count;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        case (count)
            5'd0:    increment = '0;
            5'd1:    increment = CNT_W'(40);
            5'd2:    increment = CNT_W'(100);
            5'd3:    increment = CNT_W'(300);
            default: increment = CNT_W'(1200);
        endcase
        score_sum = {1'b0, score} + {1'b0, increment};
        lines_sum = {1'b0, totalLines} + (CNT_W+1)'(count);
    end

    // A new-game clear outranks the update made as the scan finishes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            totalLines <= '0;
            score      <= '0;
        end else if (clearScore) begin
            totalLines <= '0;
            score      <= '0;
        end else if (finishing) begin
            totalLines <= lines_sum[CNT_W] ? '1 : lines_sum[CNT_W-1:0];
            score      <= score_sum[CNT_W] ? '1 : score_sum[CNT_W-1:0];
        end
    end

endmodule

// File: tb/tb_line_clear.sv
// Bench for line_clear: a countdown/collapse reference model checked every cycle,
// directed cases pinned with hand-computed literals, then randomized traffic.
module tb_line_clear;

    typedef logic [19:0][9:0] scr_t;

    logic        clk;
    logic        reset;
    logic        start;
    scr_t        screen;
    logic        clearScore;
    logic        busy;
    logic        done;
    scr_t        outputScreen;
    logic [4:0]  linesCleared;
    logic [15:0] totalLines;
    logic [15:0] score;

    int total = 0;
    int bad   = 0;

    line_clear #(.ROWS(20), .COLS(10), .CNT_W(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .screen       (screen),
        .clearScore   (clearScore),
        .busy         (busy),
        .done         (done),
        .outputScreen (outputScreen),
        .linesCleared (linesCleared),
        .totalLines   (totalLines),
        .score        (score)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int countFull(input scr_t s);
        int k = 0;
        for (int i = 0; i < 20; i++) if (s[i] == 10'h3FF) k++;
        return k;
    endfunction

    function automatic scr_t collapse(input scr_t s);
        scr_t o = '0;
        int j = 0;
        for (int i = 0; i < 20; i++) begin
            if (s[i] != 10'h3FF) begin
                o[j] = s[i];
                j++;
            end
        end
        return o;
    endfunction

    function automatic int scoreFor(input int k);
        if (k == 0) return 0;
        if (k == 1) return 40;
        if (k == 2) return 100;
        if (k == 3) return 300;
        return 1200;
    endfunction

    function automatic int sat16(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    function automatic scr_t randScreen();
        scr_t s;
        for (int i = 0; i < 20; i++) begin
            if ($urandom_range(2) == 0) s[i] = 10'h3FF;
            else                         s[i] = 10'($urandom);
        end
        return s;
    endfunction

    // Reference model: an accepted start launches a countdown of 20+k edges, after which
    // the results of removing the k full rows appear together with a one-cycle done.
    int   m_cnt;
    logic m_done;
    int   m_k;
    scr_t m_pending;
    scr_t m_out;
    int   m_lines;
    int   m_total;
    int   m_score;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_cnt     <= 0;
            m_done    <= 1'b0;
            m_k       <= 0;
            m_pending <= '0;
            m_out     <= '0;
            m_lines   <= 0;
            m_total   <= 0;
            m_score   <= 0;
        end else begin
            if (m_done) begin
                m_done <= 1'b0;
            end else if (m_cnt > 0) begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    m_out   <= m_pending;
                    m_lines <= m_k;
                    m_total <= sat16(m_total + m_k);
                    m_score <= sat16(m_score + scoreFor(m_k));
                    m_done  <= 1'b1;
                end
            end else if (start) begin
                m_k       <= countFull(screen);
                m_pending <= collapse(screen);
                m_cnt     <= 20 + countFull(screen);
            end
            if (clearScore) begin
                m_total <= 0;
                m_score <= 0;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [199:0] act, input logic [199:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic compareAll();
        checkOutput("busy",         200'(busy),         200'((m_cnt > 0) || m_done));
        checkOutput("done",         200'(done),         200'(m_done));
        checkOutput("outputScreen", 200'(outputScreen), 200'(m_out));
        checkOutput("linesCleared", 200'(linesCleared), 200'(m_lines));
        checkOutput("totalLines",   200'(totalLines),   200'(m_total));
        checkOutput("score",        200'(score),        200'(m_score));
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        compareAll();
    endtask

    task automatic clearTotals();
        clearScore = 1'b1;
        tick();
        clearScore = 1'b0;
    endtask

    task automatic applyStimulus(input scr_t scr, output int edges);
        int guard = 0;
        while (busy && guard < 100) begin
            tick();
            guard++;
        end
        screen = scr;
        start  = 1'b1;
        tick();
        edges = 1;
        start = 1'b0;
        while (!done && edges < 80) begin
            tick();
            edges++;
        end
        checkOutput("done_timeout", 200'(done), 200'(1));
    endtask

    initial begin
        scr_t s;
        scr_t e;
        int   edges;
        int   dones;

        reset      = 1'b1;
        start      = 1'b0;
        screen     = '0;
        clearScore = 1'b0;
        @(negedge clk);
        repeat (2) tick();
        checkOutput("rst_busy",  200'(busy),  200'(0));
        checkOutput("rst_score", 200'(score), 200'(0));
        reset = 1'b0;
        tick();

        $display("[TB] empty screen");
        applyStimulus('0, edges);
        checkOutput("empty_latency", 200'(edges),        200'(21));
        checkOutput("empty_screen",  200'(outputScreen), 200'(0));
        checkOutput("empty_lines",   200'(linesCleared), 200'(0));
        checkOutput("empty_score",   200'(score),        200'(0));

        $display("[TB] single line");
        s = '0; s[0] = 10'h3FF; s[1] = 10'b0000000001;
        e = '0; e[0] = 10'b0000000001;
        applyStimulus(s, edges);
        checkOutput("one_latency", 200'(edges),        200'(22));
        checkOutput("one_screen",  200'(outputScreen), 200'(e));
        checkOutput("one_lines",   200'(linesCleared), 200'(1));
        checkOutput("one_score",   200'(score),        200'(40));
        checkOutput("one_total",   200'(totalLines),   200'(1));

        $display("[TB] four lines");
        clearTotals();
        s = '0; s[0] = 10'h3FF; s[1] = 10'h3FF; s[2] = 10'h3FF; s[3] = 10'h3FF; s[4] = 10'b1010101010;
        e = '0; e[0] = 10'b1010101010;
        applyStimulus(s, edges);
        checkOutput("four_latency", 200'(edges),        200'(25));
        checkOutput("four_screen",  200'(outputScreen), 200'(e));
        checkOutput("four_lines",   200'(linesCleared), 200'(4));
        checkOutput("four_score",   200'(score),        200'(1200));

        $display("[TB] non-contiguous clears");
        clearTotals();
        s = '0; s[2] = 10'h3FF; s[5] = 10'h3FF; s[3] = 10'h001; s[6] = 10'h200; s[7] = 10'h003;
        e = '0; e[2] = 10'h001; e[4] = 10'h200; e[5] = 10'h003;
        applyStimulus(s, edges);
        checkOutput("gap_latency", 200'(edges),        200'(23));
        checkOutput("gap_screen",  200'(outputScreen), 200'(e));
        checkOutput("gap_lines",   200'(linesCleared), 200'(2));
        checkOutput("gap_score",   200'(score),        200'(100));

        $display("[TB] start pulses during scan");
        tick();
        s = '0; s[0] = 10'h3FF;
        screen = s;
        start  = 1'b1;
        tick();
        start = 1'b0;
        dones = 0;
        for (int c = 0; c < 60; c++) begin
            start = (c == 5 || c == 20 || c == 21);
            tick();
            if (done) dones++;
        end
        start = 1'b0;
        checkOutput("restart_one_done", 200'(dones), 200'(1));

        $display("[TB] reset mid-scan");
        s = '0; s[0] = 10'h3FF; s[1] = 10'h3FF; s[2] = 10'h155;
        screen = s;
        start  = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        reset = 1'b1;
        #1;
        checkOutput("abort_busy",  200'(busy),         200'(0));
        checkOutput("abort_done",  200'(done),         200'(0));
        checkOutput("abort_score", 200'(score),        200'(0));
        checkOutput("abort_scr",   200'(outputScreen), 200'(0));
        @(negedge clk);
        tick();
        reset = 1'b0;
        dones = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (done) dones++;
        end
        checkOutput("abort_no_done", 200'(dones), 200'(0));
        e = '0; e[0] = 10'h155;
        applyStimulus(s, edges);
        checkOutput("after_abort_latency", 200'(edges),        200'(23));
        checkOutput("after_abort_screen",  200'(outputScreen), 200'(e));
        checkOutput("after_abort_score",   200'(score),        200'(100));

        $display("[TB] score saturation");
        clearTotals();
        for (int n = 0; n < 55; n++) begin
            s = randScreen();
            for (int i = 0; i < 4; i++) s[i] = 10'h3FF;
            for (int i = 4; i < 20; i++) s[i] = s[i] & 10'h1FF;
            applyStimulus(s, edges);
        end
        checkOutput("sat_score", 200'(score),      200'(16'hFFFF));
        checkOutput("sat_total", 200'(totalLines), 200'(220));

        $display("[TB] clearScore on finishing edge");
        tick();
        s = '0; s[0] = 10'h3FF;
        screen = s;
        start  = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 2; c <= 21; c++) tick();
        clearScore = 1'b1;
        tick();
        clearScore = 1'b0;
        checkOutput("clr_done",  200'(done),         200'(1));
        checkOutput("clr_score", 200'(score),        200'(0));
        checkOutput("clr_total", 200'(totalLines),   200'(0));
        checkOutput("clr_lines", 200'(linesCleared), 200'(1));

        $display("[TB] random traffic");
        for (int c = 0; c < 3000; c++) begin
            screen     = randScreen();
            start      = ($urandom_range(3) == 0);
            clearScore = ($urandom_range(15) == 0);
            tick();
        end
        start      = 1'b0;
        clearScore = 1'b0;
        repeat (45) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
